seg7_scan_capture: RTL

- Receive-side counterpart of the BCD-to-7-segment encoder.
- Monitors a scanned, multiplexed 7-segment display bus: one shared segment bus plus one-hot digit selects.
- Recovers the BCD digit shown on each position, validates stable patterns and flags illegal ones.
- Presents a complete, atomically updated frame of digits. Used for display loopback checking and for reading displays driven by other blocks.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_capture.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, BCD codes and dwell FSM states
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] BCD_ILLEGAL = 4'hE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - inverse of the BCD-to-7-segment encoder table
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_ILLEGAL;
      err = 1'b1;
      case (seg)
         SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
         SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
         SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
         SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
         SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
         SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
         SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
         SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
         SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
         SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
         SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
         default:   begin bcd = BCD_ILLEGAL; err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - recovers BCD digits from a scanned 7-segment bus
// and publishes them as atomically updated frames.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   err_out,
   output logic                    frame_valid,
   output logic                    frame_err
);

   localparam int          IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [3:0]  CNT_LAST = 4'(STABLE_CYCLES - 1);
   localparam bit          ONE_SHOT = (STABLE_CYCLES == 1);

   logic [6:0]              s_seg, ref_seg;
   logic [NUM_DIGITS-1:0]   s_sel, ref_sel;
   logic [3:0]              cnt;
   state_t                  state;

   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_err;
   logic [NUM_DIGITS-1:0]   bitmap;

   logic [3:0]              dec_bcd;
   logic                    dec_err;
   logic                    onehot, match, reload, accept, full;
   logic [IW-1:0]           sel_idx;

   seg7_pattern_decode u_decode (
      .seg (s_seg),
      .bcd (dec_bcd),
      .err (dec_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg <= '0;
         s_sel <= '0;
      end else begin
         s_seg <= seg_in;
         s_sel <= dig_sel;
      end
   end

   assign onehot = (s_sel != '0) && ((s_sel & (s_sel - NUM_DIGITS'(1))) == '0);
   assign match  = (s_sel == ref_sel) && (s_seg == ref_seg);
   assign full   = &bitmap;

   // reload = start a new dwell on the current sample; with a one-cycle
   // stability requirement that start is itself the accept.
   always_comb begin
      reload = 1'b0;
      accept = 1'b0;
      case (state)
         IDLE:    reload = onehot;
         COUNT:   if (match) accept = (cnt == CNT_LAST);
                  else       reload = onehot;
         HOLD:    if (!match) reload = onehot;
         default: reload = 1'b0;
      endcase
      if (reload && ONE_SHOT) accept = 1'b1;
   end

   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (s_sel[k]) sel_idx = IW'(k);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ref_seg <= '0;
         ref_sel <= '0;
      end else if (reload) begin
         ref_seg <= s_seg;
         ref_sel <= s_sel;
         cnt     <= 4'd1;
         state   <= ONE_SHOT ? HOLD : COUNT;
      end else begin
         case (state)
            COUNT: begin
               if (!match)      state <= IDLE;
               else if (accept) state <= HOLD;
               else             cnt   <= cnt + 4'd1;
            end
            HOLD:    if (!match) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Frame publish clears the bitmap before a coincident accept sets its bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_bcd  <= '0;
         shadow_err  <= '0;
         bitmap      <= '0;
         bcd_out     <= '0;
         err_out     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= full;
         if (full) begin
            bcd_out   <= shadow_bcd;
            err_out   <= shadow_err;
            frame_err <= |shadow_err;
         end
         bitmap <= (full ? '0 : bitmap) | (accept ? s_sel : '0);
         if (accept) begin
            shadow_bcd[{sel_idx, 2'b00} +: 4] <= dec_bcd;
            shadow_err[sel_idx]               <= dec_err;
         end
      end
   end

endmodule
